leglite_data_mem: RTL
=====================

// Module: leglite_data_mem
// PURPOSE
//  Data-memory responder for the LEGLite single-cycle core. It answers the core's daddr/dread/dwrite/dwdata
//  requests and drives ddata back to the core.
//  - Word RAM plus a small memory-mapped I/O page: LED register, synchronized switches, 16-bit timer, status.
//  - Reads are combinational, so a load completes in the same cycle. Writes commit on the rising clock edge.
// PARAMETERS
//  ADDR_BITS  7         RAM word-index width; RAM depth = 2**ADDR_BITS x 16-bit words
//  IO_BASE    16'hFF00  base byte address of the I/O page; addresses >= IO_BASE are I/O, all others are RAM
// PORTS
//  clock     in   1   system clock; all state changes on its rising edge
//  reset     in   1   asynchronous, active-low reset (0 = reset asserted)
//  daddr     in   16  byte address from core ALU; bit 0 ignored (word-aligned accesses)
//  dread     in   1   read enable from core
//  dwrite    in   1   write enable from core
//  dwdata    in   16  write data from core
//  ddata     out  16  read data to core
//  sw_in     in   8   asynchronous switch inputs
//  led_out   out  8   LED register contents
//  timer_irq out  1   sticky timer-match flag (status bit 0)
// BEHAVIOUR
//  - Reset (reset=0, async): led_out=0, timer count=0, compare=16'hFFFF, flag/timer_irq=0, sync flops=0.
//    RAM is not cleared; its contents are undefined until written. ddata is combinational, so it is 0 while dread=0.
//  - RAM decode (daddr < IO_BASE): word index = daddr[ADDR_BITS:1]; higher bits are ignored, so RAM aliases modulo depth.
//  - Read: ddata = selected word while dread=1, same cycle, zero latency. ddata=16'h0000 while dread=0.
//  - Write: when dwrite=1 at a rising edge, the selected RAM word or I/O register takes dwdata.
//  - dread and dwrite both 1: ddata shows the pre-write contents; the new value is visible from the next cycle.
//  - I/O map (offset from IO_BASE):
//      +0 LED    RW; led_out = reg[7:0]; reads return {8'h00, reg}
//      +2 SW     RO; two-flop synchronizer on sw_in, read as {8'h00, sync2}; writes ignored
//      +4 TCOUNT RW; timer count
//      +6 TCMP   RW; compare value
//      +8 STATUS bit0 = match flag; write 1 clears (W1C); other bits read 0
//      +10..+254 unmapped: reads return 0; writes ignored
//  - Timer:
//      - TCOUNT increments by 1 every cycle; 16'hFFFF wraps to 16'h0000.
//      - In a cycle where TCOUNT is written, the written value loads and that cycle's increment is skipped.
//      - Flag sets on the edge where the next count equals TCMP (count+1==TCMP, or loaded value==TCMP).
//  - STATUS W1C and a match at the same edge: set wins, so the flag stays 1.
//  - Reset asserted mid-access: pending write dropped, all registers forced to reset values immediately.
// CONFIGURATION
//  LEGLITE_DMEM_TIMER_EN defined:
//    - TCOUNT, TCMP and STATUS are implemented as above.
//  LEGLITE_DMEM_TIMER_EN undefined:
//    - No timer logic; +4/+6/+8 behave as unmapped (read 0, writes ignored).
//    - timer_irq is tied to 0.
//    - LED, SW and RAM behaviour are unchanged.
// TESTING
//  1. Reset release; write 16'hBEEF to 0x0010; read 0x0010 with dread=1 -> ddata=16'hBEEF same cycle;
//     dread=0 -> ddata=0.
//  2. Write 16'h1234 to 0x0002; read daddr=0x0102 (ADDR_BITS=7, alias) -> 16'h1234;
//     dread=dwrite=1 at 0x0002 with 16'h5555 -> 16'h1234 that cycle, 16'h5555 next cycle.
//  3. Write 16'h00A5 to 0xFF00 -> led_out=8'hA5 after edge; sw_in=8'h3C -> SW read 0x003C after 2 edges;
//     write to 0xFF02 ignored; read 0xFF20 -> 0.
//  4. (TIMER_EN) Write TCOUNT=16'hFFFE, TCMP=16'h0001 -> count 16'hFFFF, 0x0000, 0x0001;
//     timer_irq rises on edge reaching 0x0001 and stays high.
//  5. (TIMER_EN) Flag=1; write 16'h0001 to STATUS -> flag clears;
//     repeat with W1C on the same edge as a match -> flag remains 1.
//  6. Assert reset mid-write (dwrite=1 to 0xFF00, 16'h00FF) -> led_out=0 immediately, write lost;
//     without TIMER_EN, reads of 0xFF04 return 0 and timer_irq=0.

Source files
------------

// File: rtl/leglite_data_mem.sv
// leglite_data_mem
//   Data-memory responder for the LEGLite single-cycle core: a word RAM plus a
//   small memory-mapped I/O page (LED register, synchronized switches, timer).
//   Reads are combinational (zero latency); writes commit on the rising edge.
//
//   Optional feature macro: LEGLITE_DMEM_TIMER_EN
//     defined   -> TCOUNT/TCMP/STATUS registers and timer_irq are implemented
//     undefined -> +4/+6/+8 read 0 and ignore writes; timer_irq tied to 0
//
// Ports
//   clock      in   1   system clock
//   reset      in   1   asynchronous active-low reset
//   daddr      in   16  byte address (bit 0 ignored)
//   dread      in   1   read enable
//   dwrite     in   1   write enable
//   dwdata     in   16  write data
//   ddata      out  16  read data (0 while dread=0)
//   sw_in      in   8   asynchronous switch inputs
//   led_out    out  8   LED register
//   timer_irq  out  1   sticky timer-match flag
module leglite_data_mem #(
  parameter int          ADDR_BITS = 7,
  parameter logic [15:0] IO_BASE   = 16'hFF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] daddr,
  input  logic        dread,
  input  logic        dwrite,
  input  logic [15:0] dwdata,
  output logic [15:0] ddata,
  input  logic [7:0]  sw_in,
  output logic [7:0]  led_out,
  output logic        timer_irq
);

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } dmem_req_t;

  // I/O page word offsets
  localparam logic [6:0] W_LED    = 7'd0;
  localparam logic [6:0] W_SW     = 7'd1;
  localparam logic [6:0] W_TCOUNT = 7'd2;
  localparam logic [6:0] W_TCMP   = 7'd3;
  localparam logic [6:0] W_STATUS = 7'd4;

  dmem_req_t req;
  assign req = '{rd: dread, wr: dwrite, addr: daddr, wdata: dwdata};

  logic                 io_sel;
  logic [6:0]           io_word;
  logic [ADDR_BITS-1:0] ram_idx;
  logic                 io_wr;

  assign io_sel  = (req.addr >= IO_BASE);
  // Word offset inside the page; bit 0 of both operands drops out
  assign io_word = req.addr[7:1] - IO_BASE[7:1];
  // Upper address bits are ignored, so RAM aliases modulo its depth
  assign ram_idx = req.addr[ADDR_BITS:1];
  assign io_wr   = req.wr && io_sel;

  // ---------------- RAM (not reset) ----------------
  logic [15:0] mem [2**ADDR_BITS];

  // Gating with reset drops a write whose edge lands while reset is held
  always_ff @(posedge clock) begin
    if (reset && req.wr && !io_sel) mem[ram_idx] <= req.wdata;
  end

  // ---------------- LED and switch synchronizer ----------------
  logic [7:0] led_q, sw_sync1, sw_sync2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      led_q    <= 8'h00;
      sw_sync1 <= 8'h00;
      sw_sync2 <= 8'h00;
    end else begin
      sw_sync1 <= sw_in;
      sw_sync2 <= sw_sync1;
      if (io_wr && io_word == W_LED) led_q <= req.wdata[7:0];
    end
  end

  assign led_out = led_q;

  // ---------------- Timer ----------------
`ifdef LEGLITE_DMEM_TIMER_EN
  logic [15:0] tcount, tcmp, tnext;
  logic        flag;

  // A write to TCOUNT replaces that cycle's increment
  always_comb begin
    tnext = tcount + 16'd1;
    if (io_wr && io_word == W_TCOUNT) tnext = req.wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tcount <= 16'h0000;
      tcmp   <= 16'hFFFF;
      flag   <= 1'b0;
    end else begin
      tcount <= tnext;
      if (io_wr && io_word == W_TCMP) tcmp <= req.wdata;
      // Match beats a simultaneous W1C so no event is lost
      if (tnext == tcmp)                                        flag <= 1'b1;
      else if (io_wr && io_word == W_STATUS && req.wdata[0]) flag <= 1'b0;
    end
  end

  assign timer_irq = flag;
`else
  assign timer_irq = 1'b0;
`endif

  // ---------------- Read mux ----------------
  always_comb begin
    ddata = 16'h0000;
    if (req.rd) begin
      if (!io_sel) begin
        ddata = mem[ram_idx];
      end else begin
        case (io_word)
          W_LED:    ddata = {8'h00, led_q};
          W_SW:     ddata = {8'h00, sw_sync2};
`ifdef LEGLITE_DMEM_TIMER_EN
          W_TCOUNT: ddata = tcount;
          W_TCMP:   ddata = tcmp;
          W_STATUS: ddata = {15'h0000, flag};
`endif
          default:  ddata = 16'h0000;
        endcase
      end
    end
  end

`ifndef LEGLITE_DMEM_TIMER_EN
  // Offsets reserved for the timer are unused in this build
  logic unused_timer_offsets;
  assign unused_timer_offsets = ^{W_TCOUNT, W_TCMP, W_STATUS};
`endif

endmodule
